// File: rtl/rf_write_arbiter_if.sv
// Writeback/NI-to-register-file write-port bundle; master drives requests, slave drives the RF port.
// Registered outputs land one cycle after the request; the NI must hold ni_data while ni_ready is low.
interface rf_write_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          core_we;
    logic [4:0]    core_waddr;
    logic [31:0]   core_wdata;
    logic          ni_valid;
    logic [31:0]   ni_data;
    logic          ni_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          ni_grant;
    logic          stall_o;
    logic [CW-1:0] fifo_count;
    logic          err_o;

    modport master (
        output core_we, core_waddr, core_wdata, ni_valid, ni_data,
        input  ni_ready, rf_we, rf_waddr, rf_wdata, ni_grant, stall_o, fifo_count, err_o
    );

    modport slave (
        input  core_we, core_waddr, core_wdata, ni_valid, ni_data,
        output ni_ready, rf_we, rf_waddr, rf_wdata, ni_grant, stall_o, fifo_count, err_o
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port: core writeback first, queued NI words drain into a rotating register window.
// One-cycle registered latency; NI backpressured via ni_ready when full, starved NI raises stall_o.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int NI_FIRST     = 1,
    parameter int NI_LAST      = 7,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [4:0]    FIRST = 5'(NI_FIRST);
    localparam logic [4:0]    LAST  = 5'(NI_LAST);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ni_ready_q, ni_ready_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          ni_grant_q, ni_grant_d;
    logic [4:0]    ni_ptr_q, ni_ptr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          stall_prev_q, stall_prev_d;
    logic          err_q, err_d;
    logic          core_win, push, pop;

    always_comb begin
        core_win = bus.core_we && (bus.core_waddr != 5'd0);
        push     = bus.ni_valid && ni_ready_q;
        // Pop looks only at registered occupancy, so a word pushed this cycle cannot leave this cycle.
        pop      = !core_win && (count_q != '0);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.ni_data;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        ni_ready_d = (count_d < FULL);

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        ni_grant_d = 1'b0;
        ni_ptr_d   = ni_ptr_q;
        if (core_win) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.core_waddr;
            rf_wdata_d = bus.core_wdata;
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ni_ptr_q;
            rf_wdata_d = mem_q[rd_ptr_q];
            ni_grant_d = 1'b1;
            ni_ptr_d   = (ni_ptr_q == LAST) ? FIRST : ni_ptr_q + 5'd1;
        end

        starve_d = starve_q;
        if (count_q == '0 || pop) starve_d = '0;
        else if (starve_q != LIMIT) starve_d = starve_q + SW'(1);

        // Stall drops one cycle after the NI write is visible on the RF port.
        stall_d = stall_q;
        if (ni_grant_q)              stall_d = 1'b0;
        else if (starve_d == LIMIT)  stall_d = 1'b1;
        stall_prev_d = stall_q;

        err_d = err_q | (bus.core_we && stall_q && stall_prev_q);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ni_ready_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
            ni_grant_q   <= 1'b0;
            ni_ptr_q     <= FIRST;
            starve_q     <= '0;
            stall_q      <= 1'b0;
            stall_prev_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ni_ready_q   <= ni_ready_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            ni_grant_q   <= ni_grant_d;
            ni_ptr_q     <= ni_ptr_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
            stall_prev_q <= stall_prev_d;
            err_q        <= err_d;
        end
    end

    assign bus.ni_ready   = ni_ready_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.ni_grant   = ni_grant_q;
    assign bus.stall_o    = stall_q;
    assign bus.fifo_count = count_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: one task per scenario, RF writes logged per cycle and compared.
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        grant;
    } wr_t;
    wr_t obs[$];

    rf_write_arbiter_if #(.DEPTH(4)) bus ();

    rf_write_arbiter #(
        .DEPTH(4), .NI_FIRST(1), .NI_LAST(7), .STARVE_LIMIT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test sequence to finish");
        $fatal(1);
    end

    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rf_we === 1'b1) begin
            w.cyc   = cyc;
            w.addr  = bus.rf_waddr;
            w.data  = bus.rf_wdata;
            w.grant = bus.ni_grant;
            obs.push_back(w);
        end
    endtask

    task automatic idle_inputs();
        bus.core_we    = 1'b0;
        bus.core_waddr = 5'd0;
        bus.core_wdata = 32'd0;
        bus.ni_valid   = 1'b0;
        bus.ni_data    = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        obs.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
        checks++; if (bus.ni_grant !== 1'b0) begin errors++; $display("FAIL reset_ni_grant: got %b expected 0", bus.ni_grant); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
        checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", bus.rf_wdata); end
        checks++; if (bus.ni_ready !== 1'b0) begin errors++; $display("FAIL reset_ni_ready_held: got %b expected 0", bus.ni_ready); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        rst = 1'b0;
        tick();
        checks++; if (bus.ni_ready !== 1'b1) begin errors++; $display("FAIL reset_ni_ready_release: got %b expected 1", bus.ni_ready); end
    endtask

    task automatic test_basic_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.ni_valid = 1'b1;
            bus.ni_data  = 32'hA1 + i;
            tick();
        end
        bus.ni_valid = 1'b0;
        repeat (3) tick();
        checks++; if (obs.size() !== 3) begin errors++; $display("FAIL basic_count: got %0d writes expected 3", obs.size()); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].cyc !== i + 2 || obs[i].addr !== 5'(i + 1) || obs[i].data !== 32'hA1 + i || obs[i].grant !== 1'b1) begin
                errors++;
                $display("FAIL basic_word%0d: got cyc=%0d addr=%0d data=%0h grant=%b expected cyc=%0d addr=%0d data=%0h grant=1",
                         i, obs[i].cyc, obs[i].addr, obs[i].data, obs[i].grant, i + 2, i + 1, 32'hA1 + i);
            end
        end
    endtask

    task automatic test_window_wrap();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.ni_valid = 1'b1;
            bus.ni_data  = 32'h100 + i;
            tick();
        end
        bus.ni_valid = 1'b0;
        repeat (3) tick();
        checks++; if (obs.size() !== 9) begin errors++; $display("FAIL wrap_count: got %0d writes expected 9", obs.size()); end
        for (int i = 0; i < 9 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].addr !== 5'((i % 7) + 1) || obs[i].data !== 32'h100 + i) begin
                errors++;
                $display("FAIL wrap_word%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                         i, obs[i].addr, obs[i].data, (i % 7) + 1, 32'h100 + i);
            end
        end
    endtask

    task automatic test_core_priority();
        int          exp_cnt [5] = '{1, 2, 2, 1, 0};
        logic [4:0]  exp_addr[5] = '{5'd9, 5'd9, 5'd9, 5'd1, 5'd2};
        logic [31:0] exp_data[5] = '{32'h55, 32'h55, 32'h55, 32'hB0, 32'hB1};
        logic        exp_gnt [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.core_we    = (c < 3);
            bus.core_waddr = 5'd9;
            bus.core_wdata = 32'h55;
            bus.ni_valid   = (c < 2);
            bus.ni_data    = 32'hB0 + c;
            tick();
            checks++;
            if (bus.fifo_count !== 3'(exp_cnt[c])) begin
                errors++;
                $display("FAIL prio_count_cyc%0d: got %0d expected %0d", c + 1, bus.fifo_count, exp_cnt[c]);
            end
        end
        idle_inputs();
        tick();
        checks++; if (obs.size() !== 5) begin errors++; $display("FAIL prio_nwrites: got %0d expected 5", obs.size()); end
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].cyc !== i + 1 || obs[i].addr !== exp_addr[i] || obs[i].data !== exp_data[i] || obs[i].grant !== exp_gnt[i]) begin
                errors++;
                $display("FAIL prio_write%0d: got cyc=%0d addr=%0d data=%0h grant=%b expected cyc=%0d addr=%0d data=%0h grant=%b",
                         i, obs[i].cyc, obs[i].addr, obs[i].data, obs[i].grant, i + 1, exp_addr[i], exp_data[i], exp_gnt[i]);
            end
        end
    endtask

    task automatic test_full_fifo();
        wr_t ni_wr[$];
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.core_we    = 1'b1;
            bus.core_waddr = 5'd9;
            bus.core_wdata = 32'h66;
            bus.ni_valid   = 1'b1;
            bus.ni_data    = 32'hF0 + c;
            tick();
            if (c >= 3) begin
                checks++;
                if (bus.ni_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
                    errors++;
                    $display("FAIL full_push%0d: got ni_ready=%b count=%0d expected ni_ready=0 count=4", c + 1, bus.ni_ready, bus.fifo_count);
                end
            end
        end
        bus.core_we = 1'b0;
        tick();
        checks++;
        if (bus.ni_ready !== 1'b1 || bus.fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL full_release: got ni_ready=%b count=%0d expected ni_ready=1 count=3", bus.ni_ready, bus.fifo_count);
        end
        tick();
        bus.ni_valid = 1'b0;
        repeat (6) tick();
        foreach (obs[i]) if (obs[i].grant === 1'b1) ni_wr.push_back(obs[i]);
        checks++; if (ni_wr.size() !== 5) begin errors++; $display("FAIL full_nwrites: got %0d expected 5", ni_wr.size()); end
        for (int i = 0; i < 5 && i < ni_wr.size(); i++) begin
            checks++;
            if (ni_wr[i].data !== 32'hF0 + i || ni_wr[i].addr !== 5'(i + 1)) begin
                errors++;
                $display("FAIL full_word%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                         i, ni_wr[i].addr, ni_wr[i].data, i + 1, 32'hF0 + i);
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_stall;
        do_reset();
        bus.core_we    = 1'b1;
        bus.core_waddr = 5'd10;
        bus.core_wdata = 32'h77;
        bus.ni_valid   = 1'b1;
        bus.ni_data    = 32'hC0;
        tick();
        bus.ni_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            exp_stall = (k == 9) ? 1'b1 : 1'b0;
            checks++;
            if (bus.stall_o !== exp_stall) begin
                errors++;
                $display("FAIL starve_stall_cyc%0d: got %b expected %b", k, bus.stall_o, exp_stall);
            end
        end
        bus.core_we = 1'b0;
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'hC0 || bus.ni_grant !== 1'b1 || bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_ni_write: got we=%b addr=%0d data=%0h grant=%b stall=%b expected we=1 addr=1 data=c0 grant=1 stall=1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.ni_grant, bus.stall_o);
        end
        tick();
        checks++;
        if (bus.stall_o !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_release: got stall=%b err=%b expected stall=0 err=0", bus.stall_o, bus.err_o);
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        bus.core_we    = 1'b1;
        bus.core_waddr = 5'd10;
        bus.core_wdata = 32'h77;
        bus.ni_valid   = 1'b1;
        bus.ni_data    = 32'hC1;
        tick();
        bus.ni_valid = 1'b0;
        repeat (8) tick();
        tick();
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_first_stall_cycle: got %b expected 0", bus.err_o); end
        tick();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.err_o); end
        bus.core_we = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus.err_o !== 1'b1 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: got err=%b stall=%b expected err=1 stall=0", bus.err_o, bus.stall_o);
        end
        do_reset();
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_cleared_by_rst: got %b expected 0", bus.err_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.core_we    = 1'b1;
            bus.core_waddr = 5'd9;
            bus.core_wdata = 32'h88;
            bus.ni_valid   = 1'b1;
            bus.ni_data    = 32'hD0 + c;
            tick();
        end
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL midrst_queued: got %0d expected 3", bus.fifo_count); end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs.delete();
        repeat (4) tick();
        checks++;
        if (obs.size() !== 0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL midrst_discard: got writes=%0d count=%0d expected writes=0 count=0", obs.size(), bus.fifo_count);
        end
        bus.ni_valid = 1'b1;
        bus.ni_data  = 32'hDD;
        tick();
        bus.ni_valid = 1'b0;
        tick();
        checks++;
        if (obs.size() !== 1) begin
            errors++;
            $display("FAIL midrst_next_word: got %0d writes expected 1", obs.size());
        end else if (obs[0].addr !== 5'd1 || obs[0].data !== 32'hDD) begin
            errors++;
            $display("FAIL midrst_next_word: got addr=%0d data=%0h expected addr=1 data=dd", obs[0].addr, obs[0].data);
        end
    endtask

    task automatic test_zero_addr();
        do_reset();
        bus.core_we    = 1'b1;
        bus.core_waddr = 5'd0;
        bus.core_wdata = 32'h99;
        bus.ni_valid   = 1'b1;
        bus.ni_data    = 32'hE0;
        tick();
        bus.ni_valid = 1'b0;
        tick();
        bus.core_we = 1'b0;
        tick();
        checks++;
        if (obs.size() !== 1) begin
            errors++;
            $display("FAIL zero_addr_writes: got %0d writes expected 1", obs.size());
        end else if (obs[0].cyc !== 2 || obs[0].addr !== 5'd1 || obs[0].data !== 32'hE0 || obs[0].grant !== 1'b1) begin
            errors++;
            $display("FAIL zero_addr_writes: got cyc=%0d addr=%0d data=%0h grant=%b expected cyc=2 addr=1 data=e0 grant=1",
                     obs[0].cyc, obs[0].addr, obs[0].data, obs[0].grant);
        end
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_wdata !== 32'hE0) begin
            errors++;
            $display("FAIL idle_hold: got we=%b data=%0h expected we=0 data=e0", bus.rf_we, bus.rf_wdata);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_basic_drain();
        test_window_wrap();
        test_core_priority();
        test_full_fifo();
        test_starvation();
        test_protocol_error();
        test_mid_reset();
        test_zero_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the register file's single write port between the core writeback stage and the NoC network interface (NI) receive path. Core writes always win. NI words are queued in a small FIFO and drained into a rotating window of destination registers (r1..r7 by default) whenever the core is not writing. A starvation guard requests a pipeline stall so NI traffic is never blocked indefinitely. The block sits between writeback/NI and the register file write inputs.

## Interface

Parameters:
- DEPTH, 4: NI FIFO depth in words. Power of two, ≥2.
- NI_FIRST, 1: first register of the NI window.
- NI_LAST, 7: last register of the NI window. Constraint: 1 ≤ NI_FIRST ≤ NI_LAST ≤ 31.
- STARVE_LIMIT, 8: consecutive blocked cycles before a stall is requested. Must be ≥1.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- core_we  in  1  writeback write request.
- core_waddr  in  5  writeback destination register.
- core_wdata  in  32  writeback data.
- ni_valid  in  1  NI word valid.
- ni_data  in  32  NI word.
- ni_ready  out  1  FIFO can accept a word. Registered.
- rf_we  out  1  register file write enable. Registered.
- rf_waddr  out  5  register file write address. Registered.
- rf_wdata  out  32  register file write data. Registered.
- ni_grant  out  1  rf_* this cycle carries an NI word. Registered.
- stall_o  out  1  stall request to the hazard unit. Registered.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err_o  out  1  sticky protocol-error flag.

## Operation

- **Push:** a word is pushed when ni_valid && ni_ready. ni_ready = (count < DEPTH), registered from the next-state count.
- **Arbitration, evaluated each cycle:**
  - core_we && core_waddr != 0 → core wins. rf_* ← {1, core_waddr, core_wdata}.
  - core_we && core_waddr == 0 → no write (rf_we ← 0). The NI may use the port that cycle.
  - Port free and FIFO non-empty → pop the head. rf_* ← {1, ni_ptr, head}, ni_grant ← 1.
  - Otherwise rf_we ← 0, ni_grant ← 0.
- **ni_ptr:** resets to NI_FIRST. After each NI write it advances: ni_ptr == NI_LAST ? NI_FIRST : ni_ptr+1. It never leaves the window.
- **Simultaneous push and pop:** count is unchanged. The data order is preserved, and a word pushed into an empty FIFO cannot pop in the same cycle.
- **Starvation counter:** increments each cycle the FIFO is non-empty and no NI grant occurs. It clears on any NI grant or when the FIFO is empty, and saturates at STARVE_LIMIT.
- **Stall set/clear:**
  - stall_o is set the cycle after the counter reaches STARVE_LIMIT.
  - stall_o clears the cycle after the next NI grant.
- **Protocol error:** core_we asserted while stall_o has been high for ≥2 cycles sets err_o. The core still wins in that cycle. err_o clears only on rst.
- **rf_wdata when idle:** holds its last value when rf_we = 0.

## Timing

- **Latency:** request in cycle N → rf_* valid in cycle N+1. A push in cycle N is eligible to pop at the earliest in cycle N+1, so its rf_we appears in cycle N+2.
- **Reset values** (with rst high at edge N, from N+1):
  - rf_we, ni_grant, stall_o, err_o, rf_waddr, rf_wdata = 0.
  - ni_ready = 0 while rst is held, then 1 on the first edge after rst drops.
  - fifo_count = 0, ni_ptr = NI_FIRST, starvation counter = 0.
- **Reset mid-operation:** queued NI words are discarded. No rf_we is produced for them.
- **Full FIFO:** ni_ready = 0. An NI word offered while ni_ready = 0 is not taken and must be held by the NI.
- **Empty FIFO:** no pop is attempted and the starvation counter is held at 0.

## Test plan

1. **Basic NI drain.** After reset, push 0xA1, 0xA2, 0xA3 with core_we = 0 → rf_we pulses with addr 1, 2, 3 and data 0xA1..0xA3 on consecutive cycles, starting 2 cycles after the first push. ni_grant = 1 for each.
2. **Window wrap.** Push 9 words → addresses 1,2,3,4,5,6,7,1,2 in order.
3. **Core priority.** Hold core_we = 1 (addr 9, data 0x55) for 3 cycles while 2 NI words are queued → rf_waddr = 9 for 3 cycles, then NI words go to addr 1 and 2. fifo_count drops only after core_we falls.
4. **Full FIFO.** Push 5 words with DEPTH = 4 while core_we = 1 continuously → ni_ready = 0 after the 4th push, the 5th word is not taken, and fifo_count = 4.
5. **Starvation.** Queue 1 word and hold core_we = 1 (addr 10) → stall_o rises on the cycle after 8 blocked cycles. Drop core_we → NI write to addr 1, and stall_o falls the following cycle. If core_we is instead held 2 cycles into the stall → err_o = 1 and stays 1 until rst.
6. **Mid-operation reset.** Apply rst with 3 words queued → no further rf_we, fifo_count = 0, and the next NI word after reset is written to addr 1.
